memory_responder: RTL and testbench

- Responder end of the core's instruction/data memory interface.
- Accepts the request fields carried by Bundle::MemoryIn and returns the response fields carried by Bundle::MemoryOut, from an internal word-organised RAM.
- Fully pipelined with fixed response latency and in-order responses; after every reset it zero-initialises its storage.
- Instantiated once per memory port (imem, dmem) in the SoC top, beside the core.

---
 rtl/memory_responder.sv | 187 ++++++++++++++++++
 tb/tb_memory_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: pipelined word RAM responder for imem/dmem ports.
// Zero-fills storage after reset, then answers in order at fixed latency.
module memory_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_cnt_nxt;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            is_b;
  logic            is_h;
  logic            is_w;
  logic            is_sgn;
  logic            typ_ok;
  logic            misalign;
  logic            oor;
  logic            err;
  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   widx;
  logic [3:0]      be;
  logic [31:0]     wsh;
  logic [31:0]     rword;
  logic [31:0]     rsh;
  logic [31:0]     rdata;
  logic [31:0]     res_d;

  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];

  // Decode the access width and signedness from typ.
  always_comb begin
    is_b   = 1'b0;
    is_h   = 1'b0;
    is_w   = 1'b0;
    is_sgn = 1'b0;
    unique case (req_typ)
      3'b001: begin
        is_b   = 1'b1;
        is_sgn = 1'b1;
      end
      3'b010: begin
        is_h   = 1'b1;
        is_sgn = 1'b1;
      end
      3'b011: is_w = 1'b1;
      3'b101: is_b = 1'b1;
      3'b110: is_h = 1'b1;
      default: ;
    endcase
  end

  assign typ_ok   = is_b | is_h | is_w;
  assign misalign = (is_h & req_addr[0]) |
                    (is_w & (|req_addr[1:0]));
  assign oor      = |req_addr[31:AW+2];
  assign err      = ~typ_ok | misalign | oor;
  assign accept   = req_valid & req_ready;
  assign wr_en    = accept & req_fcn & ~err;
  assign widx     = req_addr[AW+1:2];
  assign req_ready = (state == READY);

  // Byte enables and lane-replicated store data.
  always_comb begin
    be  = 4'h0;
    wsh = req_wdata;
    unique case (1'b1)
      is_w: begin
        be  = 4'hF;
        wsh = req_wdata;
      end
      is_h: begin
        be  = req_addr[1] ? 4'hC : 4'h3;
        wsh = {2{req_wdata[15:0]}};
      end
      is_b: begin
        be  = 4'b0001 << req_addr[1:0];
        wsh = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the load result.
  always_comb begin
    rword = mem[widx];
    rsh   = rword >> {req_addr[1:0], 3'b000};
    rdata = '0;
    unique case (1'b1)
      is_w: rdata = rword;
      is_h: rdata = {{16{is_sgn & rsh[15]}}, rsh[15:0]};
      is_b: rdata = {{24{is_sgn & rsh[7]}}, rsh[7:0]};
      default: ;
    endcase
    res_d = (err | req_fcn) ? '0 : rdata;
  end

  // FSM state and clear counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Sweep every word once, then stay ready.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
          state_nxt = READY;
        end
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  // RAM write port: zero fill while clearing, byte-masked stores after.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

  // Response shift pipeline; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept & err;
      pd[0] <= accept ? res_d : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign resp_valid = pv[LATENCY-1];
  assign resp_error = pv[LATENCY-1] & pe[LATENCY-1];
  assign resp_data  = pv[LATENCY-1] ? pd[LATENCY-1] : '0;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized and directed checks of memory_responder
// against a byte-array reference model with a timed response queue.
module tb_memory_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  localparam logic [2:0] BS = 3'b001;
  localparam logic [2:0] HS = 3'b010;
  localparam logic [2:0] WD = 3'b011;
  localparam logic [2:0] BU = 3'b101;
  localparam logic [2:0] HU = 3'b110;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;

  memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_fcn(req_fcn),
    .req_typ(req_typ),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_error(resp_error)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [4*DEPTH];
  int          n;
  int          rel_n;
  bit          in_reset;
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic bit ready_exp();
    return !in_reset && (n >= rel_n + DEPTH);
  endfunction

  task automatic check_outputs();
    if (q.size() > 0 && q[0].due == n) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_data", resp_data, q[0].d);
      check("resp_error", 32'(resp_error), 32'(q[0].e));
      void'(q.pop_front());
    end else begin
      check("resp_idle_valid", 32'(resp_valid), 32'd0);
      check("resp_idle_data", resp_data, 32'd0);
      check("resp_idle_error", 32'(resp_error), 32'd0);
    end
    check("req_ready", 32'(req_ready), 32'(ready_exp()));
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] wd,
                       input logic fcn, input logic [2:0] typ);
    int          nb;
    bit          sg;
    bit          ok;
    bit          e;
    logic [31:0] v;
    exp_t        x;
    nb = 1;
    sg = 1'b0;
    ok = 1'b1;
    case (typ)
      BS: begin nb = 1; sg = 1'b1; end
      HS: begin nb = 2; sg = 1'b1; end
      WD: nb = 4;
      BU: nb = 1;
      HU: nb = 2;
      default: ok = 1'b0;
    endcase
    e = !ok || ((a % nb) != 0) || ((a >> 2) >= 32'(DEPTH));
    v = '0;
    if (!e) begin
      if (fcn) begin
        for (int k = 0; k < nb; k++) begin
          ref_mem[int'(a) + k] = wd[8*k +: 8];
        end
      end else begin
        for (int k = 0; k < nb; k++) begin
          v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
        end
        if (sg && v[8*nb-1]) begin
          v = v | ~((32'h1 << (8*nb)) - 32'h1);
        end
      end
    end
    x.due = n + LAT;
    x.d   = v;
    x.e   = e;
    q.push_back(x);
  endtask

  task automatic tick(input logic v, input logic [31:0] a,
                      input logic [31:0] wd, input logic fcn,
                      input logic [2:0] typ);
    @(negedge clk);
    n++;
    check_outputs();
    req_valid = v;
    req_addr  = a;
    req_wdata = wd;
    req_fcn   = fcn;
    req_typ   = typ;
    if (v && ready_exp()) model(a, wd, fcn, typ);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) tick(1'b0, 32'h0, 32'h0, 1'b0, WD);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] typ);
    tick(1'b1, a, $urandom, 1'b0, typ);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] typ);
    tick(1'b1, a, wd, 1'b1, typ);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n++;
    check_outputs();
    reset     = 1'b0;
    in_reset  = 1'b1;
    req_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    idle(2);
    @(negedge clk);
    n++;
    check_outputs();
    reset    = 1'b1;
    in_reset = 1'b0;
    rel_n    = n;
    repeat (DEPTH) rd(32'h3C, WD);
  endtask

  initial begin
    reset     = 1'b0;
    in_reset  = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_fcn   = 1'b0;
    req_typ   = WD;
    n         = 0;
    rel_n     = 0;
    n_tests   = 0;
    n_fail    = 0;

    do_reset();
    idle(3);

    for (int i = 0; i < DEPTH; i++) wr(32'(4*i), $urandom, WD);
    rd(32'h3C, WD);
    do_reset();
    rd(32'h3C, WD);
    idle(LAT + 1);

    wr(32'h10, 32'h80FF7F01, WD);
    rd(32'h10, BS);
    rd(32'h13, BS);
    rd(32'h13, BU);
    rd(32'h12, HS);
    rd(32'h10, HU);
    idle(2);

    wr(32'h20, 32'hAABBCCDD, WD);
    wr(32'h21, 32'h00000011, BU);
    rd(32'h20, WD);
    idle(2);

    rd(32'h05, HS);
    wr(32'h22, 32'h12345678, WD);
    rd(32'(4*DEPTH), WD);
    rd(32'h20, 3'b111);
    wr(32'h20, 32'hDEADBEEF, 3'b111);
    wr(32'h40000020, 32'hDEADBEEF, WD);
    rd(32'h20, WD);
    rd(32'h04, WD);
    idle(2);

    for (int i = 1; i <= 4; i++) begin
      wr(32'h18, 32'(i), WD);
      rd(32'h18, WD);
    end
    idle(LAT + 1);

    rd(32'h10, WD);
    rd(32'h20, WD);
    do_reset();
    for (int i = 0; i < DEPTH; i++) rd(32'(4*i), WD);
    idle(LAT + 1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int          pick;
      pick = $urandom_range(0, 15);
      if (pick == 0) a = $urandom;
      else if (pick == 1) a = 32'($urandom_range(4*DEPTH, 4*DEPTH + 40));
      else a = 32'($urandom_range(0, 4*DEPTH - 1));
      case ($urandom_range(0, 6))
        0: t = BS;
        1: t = HS;
        2: t = WD;
        3: t = BU;
        4: t = HU;
        5: t = WD;
        default: t = 3'($urandom_range(0, 7));
      endcase
      tick(1'($urandom_range(0, 3) != 0), a, $urandom,
           1'($urandom_range(0, 1)), t);
    end

    idle(LAT + 2);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
